// File: rtl/ts_scram_pkt_fifo.sv
// Packet-granular byte buffer between the TS scrambler and the J.83 reader.
// Commits only whole 188-byte packets, drops on overflow, stuffs null packets on underrun.
module ts_scram_pkt_fifo #(
    parameter int P_PKT_DEPTH = 4,
    parameter int P_PKT_LEN   = 188,
    parameter bit P_NULL_EN   = 1'b1,
    parameter int P_CNT_WIDTH = 16,
    parameter int U_DLY       = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    input  logic                         wr_sop,
    input  logic                         wr_eop,
    input  logic [7:0]                   wr_data,
    input  logic                         rd_req,
    output logic                         rd_valid,
    output logic                         rd_sop,
    output logic [7:0]                   rd_data,
    output logic [$clog2(P_PKT_DEPTH):0] pkt_level,
    output logic [P_CNT_WIDTH-1:0]       drop_cnt,
    output logic [P_CNT_WIDTH-1:0]       null_cnt,
    output logic [P_CNT_WIDTH-1:0]       err_cnt
);

    localparam int LW = $clog2(P_PKT_DEPTH) + 1;
    localparam int AW = $clog2(P_PKT_DEPTH * P_PKT_LEN);
    localparam int OW = $clog2(P_PKT_LEN);

    localparam logic [OW-1:0] LAST_OFF  = OW'(P_PKT_LEN - 1);
    localparam logic [AW-1:0] LAST_BASE = AW'((P_PKT_DEPTH - 1) * P_PKT_LEN);
    localparam logic [LW-1:0] FULL_LVL  = LW'(P_PKT_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_BOUND, R_DATA, R_NULL} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic [OW-1:0] wr_off_q, wr_off_d;
    logic [OW-1:0] rd_off_q, rd_off_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [LW-1:0] pkt_level_q, pkt_level_d;

    logic [P_CNT_WIDTH-1:0] drop_cnt_q, null_cnt_q, err_cnt_q;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic          sop_start;
    logic          commit, release_pkt;
    logic          drop_inc, err_inc, null_inc;
    logic          emit, emit_null;
    logic [7:0]    null_byte;

    logic          rd_valid_q, rd_sop_q, rd_from_mem_q;
    logic [7:0]    rd_null_byte_q;
    logic [7:0]    mem_rdata_q;
    logic [7:0]    mem [P_PKT_DEPTH * P_PKT_LEN];

    // U_DLY only shaped simulation delays in older flows; it has no effect on this logic.
    logic unused_u_dly;
    assign unused_u_dly = (U_DLY != 0);

    function automatic logic [AW-1:0] next_base(input logic [AW-1:0] base);
        return (base == LAST_BASE) ? '0 : base + AW'(P_PKT_LEN);
    endfunction

    function automatic logic [P_CNT_WIDTH-1:0] sat_inc(input logic [P_CNT_WIDTH-1:0] v,
                                                       input logic              inc);
        return (inc && (v != '1)) ? v + P_CNT_WIDTH'(1) : v;
    endfunction

    // ---------------------------------------------------------------- write side
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_off_d   = wr_off_q;
        wr_base_d  = wr_base_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_base_q + AW'(wr_off_q);
        sop_start  = 1'b0;
        commit     = 1'b0;
        drop_inc   = 1'b0;
        err_inc    = 1'b0;
        if (wr_valid) begin
            case (wr_state_q)
                W_FILL: begin
                    if (wr_sop) begin
                        err_inc   = 1'b1;
                        sop_start = 1'b1;
                    end else if (wr_off_q == LAST_OFF) begin
                        if (wr_eop) begin
                            mem_we     = 1'b1;
                            commit     = 1'b1;
                            wr_base_d  = next_base(wr_base_q);
                            wr_off_d   = '0;
                            wr_state_d = W_IDLE;
                        end else begin
                            // Packet longer than P_PKT_LEN: swallow the tail up to its eop.
                            err_inc    = 1'b1;
                            wr_off_d   = '0;
                            wr_state_d = W_DROP;
                        end
                    end else if (wr_eop) begin
                        err_inc    = 1'b1;
                        wr_off_d   = '0;
                        wr_state_d = W_IDLE;
                    end else begin
                        mem_we   = 1'b1;
                        wr_off_d = wr_off_q + OW'(1);
                    end
                end
                default: begin
                    if (wr_sop) begin
                        sop_start = 1'b1;
                    end else if (wr_eop && (wr_state_q == W_DROP)) begin
                        wr_state_d = W_IDLE;
                    end
                end
            endcase
            if (sop_start) begin
                wr_off_d = '0;
                if (pkt_level_q == FULL_LVL) begin
                    drop_inc   = 1'b1;
                    wr_state_d = wr_eop ? W_IDLE : W_DROP;
                end else if (wr_eop) begin
                    err_inc    = 1'b1;
                    wr_state_d = W_IDLE;
                end else begin
                    mem_we     = 1'b1;
                    mem_waddr  = wr_base_q;
                    wr_off_d   = OW'(1);
                    wr_state_d = W_FILL;
                end
            end
        end
    end

    // ---------------------------------------------------------------- read side
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_off_d    = rd_off_q;
        rd_base_d   = rd_base_q;
        emit        = 1'b0;
        emit_null   = 1'b0;
        null_inc    = 1'b0;
        release_pkt = 1'b0;
        mem_raddr   = rd_base_q + AW'(rd_off_q);
        if (rd_req) begin
            case (rd_state_q)
                R_BOUND: begin
                    if (pkt_level_q != '0) begin
                        emit       = 1'b1;
                        rd_off_d   = OW'(1);
                        rd_state_d = R_DATA;
                    end else if (P_NULL_EN) begin
                        emit       = 1'b1;
                        emit_null  = 1'b1;
                        null_inc   = 1'b1;
                        rd_off_d   = OW'(1);
                        rd_state_d = R_NULL;
                    end
                end
                R_DATA: begin
                    emit = 1'b1;
                    if (rd_off_q == LAST_OFF) begin
                        release_pkt = 1'b1;
                        rd_base_d   = next_base(rd_base_q);
                        rd_off_d    = '0;
                        rd_state_d  = R_BOUND;
                    end else begin
                        rd_off_d = rd_off_q + OW'(1);
                    end
                end
                default: begin
                    emit      = 1'b1;
                    emit_null = 1'b1;
                    if (rd_off_q == LAST_OFF) begin
                        rd_off_d   = '0;
                        rd_state_d = R_BOUND;
                    end else begin
                        rd_off_d = rd_off_q + OW'(1);
                    end
                end
            endcase
        end
    end

    // Null packet: header 47 1F FF 10 (PID 0x1FFF, payload only), then 0xFF stuffing.
    always_comb begin
        null_byte = 8'hFF;
        if (rd_off_q == '0)          null_byte = 8'h47;
        else if (rd_off_q == OW'(1)) null_byte = 8'h1F;
        else if (rd_off_q == OW'(3)) null_byte = 8'h10;
    end

    always_comb begin
        pkt_level_d = pkt_level_q;
        if (commit && !release_pkt)      pkt_level_d = pkt_level_q + LW'(1);
        else if (!commit && release_pkt) pkt_level_d = pkt_level_q - LW'(1);
    end

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q     <= W_IDLE;
            rd_state_q     <= R_BOUND;
            wr_off_q       <= '0;
            rd_off_q       <= '0;
            wr_base_q      <= '0;
            rd_base_q      <= '0;
            pkt_level_q    <= '0;
            drop_cnt_q     <= '0;
            null_cnt_q     <= '0;
            err_cnt_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_sop_q       <= 1'b0;
            rd_from_mem_q  <= 1'b0;
            rd_null_byte_q <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_off_q    <= wr_off_d;
            rd_off_q    <= rd_off_d;
            wr_base_q   <= wr_base_d;
            rd_base_q   <= rd_base_d;
            pkt_level_q <= pkt_level_d;
            drop_cnt_q  <= sat_inc(drop_cnt_q, drop_inc);
            null_cnt_q  <= sat_inc(null_cnt_q, null_inc);
            err_cnt_q   <= sat_inc(err_cnt_q, err_inc);
            rd_valid_q  <= emit;
            rd_sop_q    <= emit && (rd_state_q == R_BOUND);
            if (emit) begin
                rd_from_mem_q  <= !emit_null;
                rd_null_byte_q <= null_byte;
            end
        end
    end

    // NOTE: the packet RAM is deliberately not reset; pointers and level alone decide which bytes are live.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= wr_data;
        if (emit && !emit_null) mem_rdata_q <= mem[mem_raddr];
    end

    assign rd_valid  = rd_valid_q;
    assign rd_sop    = rd_sop_q;
    assign rd_data   = rd_from_mem_q ? mem_rdata_q : rd_null_byte_q;
    assign pkt_level = pkt_level_q;
    assign drop_cnt  = drop_cnt_q;
    assign null_cnt  = null_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
